// File: rtl/button_repeat_conditioner.sv
// ============================================================================
// button_repeat_conditioner: sync + debounce a pushbutton, emit press/release
// pulses, enable the refresh counter while held and auto-repeat on its tick.
// Revision: 1.0
// ============================================================================
`default_nettype none

module button_repeat_conditioner #(
  parameter int SYNC_STAGES        = 2,
  parameter int DEBOUNCE_CYCLES    = 500000,
  parameter int REPEAT_DELAY_TICKS = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  input  logic tick_in,
  output logic btn_level,
  output logic hold_en,
  output logic press_pulse,
  output logic repeat_pulse,
  output logic release_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(REPEAT_DELAY_TICKS + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HELD   = 2'd1,
    S_REPEAT = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_level;
  state_t                 r_state;
  logic [TW-1:0]          r_tcnt;
  logic                   r_hold_en;
  logic                   r_press;
  logic                   r_repeat;
  logic                   r_release;

  logic w_sync;
  logic w_toggle;
  logic w_rise;
  logic w_fall;

  assign w_sync   = r_sync[SYNC_STAGES-1];
  assign w_toggle = (w_sync != r_level) && (r_cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign w_rise   = w_toggle & w_sync;
  assign w_fall   = w_toggle & ~w_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], btn_raw};
    end
  end

  // Any disagreement that does not persist for the full window restarts the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (w_sync == r_level) begin
      r_cnt <= '0;
    end else if (w_toggle) begin
      r_cnt   <= '0;
      r_level <= w_sync;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_tcnt    <= '0;
      r_hold_en <= 1'b0;
      r_press   <= 1'b0;
      r_repeat  <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_press   <= 1'b0;
      r_repeat  <= 1'b0;
      r_release <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            r_state   <= S_HELD;
            r_tcnt    <= '0;
            r_hold_en <= 1'b1;
            r_press   <= 1'b1;
          end
        end
        S_HELD: begin
          if (w_fall) begin
            r_state   <= S_IDLE;
            r_tcnt    <= '0;
            r_hold_en <= 1'b0;
            r_release <= 1'b1;
          end else if (tick_in && !r_press) begin
            // The tick that completes the delay only arms repeating.
            if (r_tcnt == TW'(REPEAT_DELAY_TICKS - 1)) begin
              r_state <= S_REPEAT;
              r_tcnt  <= TW'(REPEAT_DELAY_TICKS);
            end else begin
              r_tcnt <= r_tcnt + TW'(1);
            end
          end
        end
        S_REPEAT: begin
          if (w_fall) begin
            r_state   <= S_IDLE;
            r_tcnt    <= '0;
            r_hold_en <= 1'b0;
            r_release <= 1'b1;
          end else if (tick_in) begin
            r_repeat <= 1'b1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_tcnt    <= '0;
          r_hold_en <= 1'b0;
        end
      endcase
    end
  end

  assign btn_level     = r_level;
  assign hold_en       = r_hold_en;
  assign press_pulse   = r_press;
  assign repeat_pulse  = r_repeat;
  assign release_pulse = r_release;

endmodule

`default_nettype wire
